// File: rtl/add_sub_chunked_pkg.sv
// Shared types for the chunked add/subtract unit: FSM state encoding and
// the WIDTH/CHUNK legality check used at elaboration.
package add_sub_chunked_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/add_sub_chunked_if.sv
// Operand/result handshake bundle for add_sub_chunked.
interface add_sub_chunked_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] x;
  logic             sub;
  logic             CIN;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic             COUT;
  logic             ovf;

  modport master (
    output in_valid, z, x, sub, CIN, out_ready,
    input  in_ready, out_valid, a, COUT, ovf
  );

  modport slave (
    input  in_valid, z, x, sub, CIN, out_ready,
    output in_ready, out_valid, a, COUT, ovf
  );
endinterface

// File: rtl/add_sub_chunked_add_chunk_cin.sv
// Combinational W-bit adder with carry in/out; time-shared across chunks.
module add_chunk_cin #(
  parameter int W = 8
) (
  input  logic [W-1:0] z,
  input  logic [W-1:0] x,
  input  logic         CIN,
  output logic [W-1:0] a,
  output logic         COUT
);
  assign {COUT, a} = {1'b0, z} + {1'b0, x} + {{W{1'b0}}, CIN};
endmodule

// File: rtl/add_sub_chunked.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per RUN cycle through a
// single shared adder, result held in DONE until the consumer takes it.
module add_sub_chunked
  import add_sub_chunked_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  add_sub_chunked_if.slave bus
);
  localparam int N   = WIDTH / CHUNK;
  localparam int K_W = (N > 1) ? $clog2(N) : 1;

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("add_sub_chunked: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0] z_q, z_d;
  // x is stored already inverted for subtract, so the chunk loop is mode-agnostic
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             carry_q, carry_d;

  int               k_base;
  logic [CHUNK-1:0] cz, cx, cs;
  logic             cco;

  assign k_base = 32'(k_q) * CHUNK;
  assign cz     = z_q[k_base +: CHUNK];
  assign cx     = x_q[k_base +: CHUNK];

  add_chunk_cin #(.W(CHUNK)) u_chunk (
    .z    (cz),
    .x    (cx),
    .CIN  (carry_q),
    .a    (cs),
    .COUT (cco)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    z_d     = z_q;
    x_d     = x_q;
    a_d     = a_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          z_d     = bus.z;
          x_d     = bus.sub ? ~bus.x : bus.x;
          carry_d = bus.sub ? 1'b1 : bus.CIN;
          a_d     = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d[k_base +: CHUNK] = cs;
        carry_d              = cco;
        if (k_q == K_W'(N - 1)) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= IDLE;
      k_q     <= '0;
      z_q     <= '0;
      x_q     <= '0;
      a_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      z_q     <= z_d;
      x_q     <= x_d;
      a_q     <= a_d;
      carry_q <= carry_d;
    end
  end

  logic done;
  assign done          = (state_q == DONE);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = done;
  assign bus.a         = done ? a_q : '0;
  assign bus.COUT      = done & carry_q;
  // signed overflow: like-signed effective operands, result sign flipped
  assign bus.ovf       = done & (z_q[WIDTH-1] == x_q[WIDTH-1]) & (a_q[WIDTH-1] != z_q[WIDTH-1]);

endmodule

// File: tb/tb_add_sub_chunked.sv
// Bench for add_sub_chunked: three instances (CHUNK = 8, 32, 1) against a
// signed/unsigned arithmetic reference model.
module tb_add_sub_chunked;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        in_valid_s [3];
  logic [31:0] z_s        [3];
  logic [31:0] x_s        [3];
  logic        sub_s      [3];
  logic        cin_s      [3];
  logic        out_ready_s[3];
  logic        in_ready_s [3];
  logic        out_valid_s[3];
  logic [31:0] a_s        [3];
  logic        cout_s     [3];
  logic        ovf_s      [3];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 8 : ((g == 1) ? 32 : 1);
    add_sub_chunked_if #(.WIDTH(32)) bus ();
    add_sub_chunked #(.WIDTH(32), .CHUNK(CH)) u_dut (
      .CLK    (clk),
      .RESETN (rstn),
      .bus    (bus)
    );
    assign bus.in_valid    = in_valid_s[g];
    assign bus.z           = z_s[g];
    assign bus.x           = x_s[g];
    assign bus.sub         = sub_s[g];
    assign bus.CIN         = cin_s[g];
    assign bus.out_ready   = out_ready_s[g];
    assign in_ready_s[g]   = bus.in_ready;
    assign out_valid_s[g]  = bus.out_valid;
    assign a_s[g]          = bus.a;
    assign cout_s[g]       = bus.COUT;
    assign ovf_s[g]        = bus.ovf;
  end

  function automatic int n_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 32);
  endfunction

  // Reference: plain integer arithmetic, overflow as signed-range escape.
  function automatic void ref_model(input logic [31:0] z, input logic [31:0] x,
                                    input logic sub, input logic cin,
                                    output logic [31:0] a, output logic cout,
                                    output logic ovf);
    longint      sr;
    logic [32:0] ur;
    if (sub) begin
      sr   = longint'($signed(z)) - longint'($signed(x));
      a    = z - x;
      cout = (z >= x);
    end else begin
      sr   = longint'($signed(z)) + longint'($signed(x)) + longint'(cin);
      ur   = {1'b0, z} + {1'b0, x} + {32'b0, cin};
      a    = ur[31:0];
      cout = ur[32];
    end
    ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  // Issue one op on instance d, scramble inputs after accept, count latency.
  task automatic do_op(input int d, input logic [31:0] z, input logic [31:0] x,
                       input logic sub, input logic cin,
                       output logic [31:0] a, output logic cout, output logic ovf,
                       output int lat);
    int guard = 0;
    @(negedge clk);
    while (!in_ready_s[d] && guard < 200) begin @(negedge clk); guard++; end
    n_tests++;
    if (in_ready_s[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL op_ready dut%0d: in_ready=%b required 1", d, in_ready_s[d]);
    end
    z_s[d] = z; x_s[d] = x; sub_s[d] = sub; cin_s[d] = cin; in_valid_s[d] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[d] = 1'b0;
    z_s[d] = $urandom; x_s[d] = $urandom;
    sub_s[d] = 1'($urandom_range(0, 1)); cin_s[d] = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid_s[d] && lat < 100) begin @(posedge clk); #1; lat++; end
    a = a_s[d]; cout = cout_s[d]; ovf = ovf_s[d];
    @(negedge clk); out_ready_s[d] = 1'b1;
    @(posedge clk); #1; out_ready_s[d] = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_tests += 5;
      if (in_ready_s[d] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready dut%0d: got %b want 1", d, in_ready_s[d]); end
      if (out_valid_s[d] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid dut%0d: got %b want 0", d, out_valid_s[d]); end
      if (a_s[d] !== 32'h0) begin n_fail++; $display("FAIL reset_a dut%0d: got %h want 0", d, a_s[d]); end
      if (cout_s[d] !== 1'b0) begin n_fail++; $display("FAIL reset_cout dut%0d: got %b want 0", d, cout_s[d]); end
      if (ovf_s[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ovf dut%0d: got %b want 0", d, ovf_s[d]); end
    end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_directed(input int d);
    logic [31:0] vz[5], vx[5], ea[5];
    logic        vs[5], vc[5], ec[5], eo[5];
    logic [31:0] a; logic c, o; int lat;
    vz = '{32'h000000FF, 32'd5, 32'd7, 32'h7FFFFFFF, 32'hFFFFFFFF};
    vx = '{32'h00000001, 32'd7, 32'd5, 32'h00000001, 32'h00000000};
    vs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ea = '{32'h00000100, 32'hFFFFFFFE, 32'h00000002, 32'h80000000, 32'h00000000};
    ec = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    eo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      do_op(d, vz[i], vx[i], vs[i], vc[i], a, c, o, lat);
      n_tests += 4;
      if (a !== ea[i]) begin n_fail++; $display("FAIL dir%0d_a dut%0d: got %h want %h", i, d, a, ea[i]); end
      if (c !== ec[i]) begin n_fail++; $display("FAIL dir%0d_cout dut%0d: got %b want %b", i, d, c, ec[i]); end
      if (o !== eo[i]) begin n_fail++; $display("FAIL dir%0d_ovf dut%0d: got %b want %b", i, d, o, eo[i]); end
      if (lat != n_of(d)) begin n_fail++; $display("FAIL dir%0d_latency dut%0d: got %0d want %0d", i, d, lat, n_of(d)); end
    end
  endtask

  task automatic test_random(input int d, input int count);
    logic [31:0] z, x, a, ea; logic s, ci, c, o, ec, eo; int lat;
    for (int i = 0; i < count; i++) begin
      z = $urandom; x = $urandom;
      if (i % 4 == 1) z = {z[31], {31{~z[31]}}};
      if (i % 4 == 2) x = {x[31], {31{x[31]}}};
      s = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      ref_model(z, x, s, ci, ea, ec, eo);
      do_op(d, z, x, s, ci, a, c, o, lat);
      n_tests += 4;
      if (a !== ea) begin n_fail++; $display("FAIL rnd_a dut%0d z=%h x=%h sub=%b cin=%b: got %h want %h", d, z, x, s, ci, a, ea); end
      if (c !== ec) begin n_fail++; $display("FAIL rnd_cout dut%0d z=%h x=%h sub=%b: got %b want %b", d, z, x, s, c, ec); end
      if (o !== eo) begin n_fail++; $display("FAIL rnd_ovf dut%0d z=%h x=%h sub=%b: got %b want %b", d, z, x, s, o, eo); end
      if (lat != n_of(d)) begin n_fail++; $display("FAIL rnd_latency dut%0d: got %0d want %0d", d, lat, n_of(d)); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] ea; logic ec, eo; int w = 0;
    ref_model(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, ea, ec, eo);
    @(negedge clk);
    z_s[0] = 32'h7FFFFFFF; x_s[0] = 32'hFFFFFFFF; sub_s[0] = 1'b1; cin_s[0] = 1'b0; in_valid_s[0] = 1'b1;
    @(posedge clk); #1; in_valid_s[0] = 1'b0;
    while (!out_valid_s[0] && w < 100) begin @(posedge clk); #1; w++; end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      in_valid_s[0] = 1'b1; z_s[0] = $urandom; x_s[0] = $urandom; sub_s[0] = 1'b0;
      @(posedge clk); #1;
      n_tests += 5;
      if (a_s[0] !== ea) begin n_fail++; $display("FAIL hold_a cyc%0d: got %h want %h", cyc, a_s[0], ea); end
      if (cout_s[0] !== ec) begin n_fail++; $display("FAIL hold_cout cyc%0d: got %b want %b", cyc, cout_s[0], ec); end
      if (ovf_s[0] !== eo) begin n_fail++; $display("FAIL hold_ovf cyc%0d: got %b want %b", cyc, ovf_s[0], eo); end
      if (in_ready_s[0] !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready cyc%0d: got %b want 0", cyc, in_ready_s[0]); end
      if (out_valid_s[0] !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid cyc%0d: got %b want 1", cyc, out_valid_s[0]); end
    end
    @(negedge clk); in_valid_s[0] = 1'b0; out_ready_s[0] = 1'b1;
    @(posedge clk); #1; out_ready_s[0] = 1'b0;
    n_tests += 2;
    if (in_ready_s[0] !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready_s[0]); end
    if (out_valid_s[0] !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b want 0", out_valid_s[0]); end
    repeat (6) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid_s[0] !== 1'b0) begin n_fail++; $display("FAIL ignored_pulses: out_valid=%b want 0", out_valid_s[0]); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] a, ea; logic c, o, ec, eo; int lat;
    @(negedge clk);
    z_s[0] = 32'h12345678; x_s[0] = 32'h0FEDCBA9; sub_s[0] = 1'b0; cin_s[0] = 1'b1; in_valid_s[0] = 1'b1;
    @(posedge clk); #1; in_valid_s[0] = 1'b0;
    @(posedge clk); #1; rstn = 1'b0;
    @(posedge clk); #1;
    n_tests += 3;
    if (in_ready_s[0] !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b want 1", in_ready_s[0]); end
    if (out_valid_s[0] !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %b want 0", out_valid_s[0]); end
    if (a_s[0] !== 32'h0) begin n_fail++; $display("FAIL abort_a: got %h want 0", a_s[0]); end
    rstn = 1'b1;
    ref_model(32'h80000000, 32'h00000001, 1'b1, 1'b1, ea, ec, eo);
    do_op(0, 32'h80000000, 32'h00000001, 1'b1, 1'b1, a, c, o, lat);
    n_tests += 4;
    if (a !== ea) begin n_fail++; $display("FAIL post_abort_a: got %h want %h", a, ea); end
    if (c !== ec) begin n_fail++; $display("FAIL post_abort_cout: got %b want %b", c, ec); end
    if (o !== eo) begin n_fail++; $display("FAIL post_abort_ovf: got %b want %b", o, eo); end
    if (lat != 4) begin n_fail++; $display("FAIL post_abort_latency: got %0d want 4", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea; logic ec, eo; int prev = -1; int pulses = 0;
    @(negedge clk);
    z_s[0] = $urandom; x_s[0] = $urandom; sub_s[0] = 1'b1; cin_s[0] = 1'b0;
    ref_model(z_s[0], x_s[0], 1'b1, 1'b0, ea, ec, eo);
    in_valid_s[0] = 1'b1; out_ready_s[0] = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (out_valid_s[0]) begin
        pulses++;
        n_tests++;
        if (a_s[0] !== ea) begin n_fail++; $display("FAIL b2b_a edge%0d: got %h want %h", e, a_s[0], ea); end
        if (prev >= 0) begin
          n_tests++;
          if (e - prev != 6) begin n_fail++; $display("FAIL b2b_period: got %0d want 6", e - prev); end
        end
        prev = e;
      end
    end
    n_tests++;
    if (pulses != 5) begin n_fail++; $display("FAIL b2b_count: got %0d want 5", pulses); end
    in_valid_s[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1; out_ready_s[0] = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid_s[d] = 1'b0; z_s[d] = '0; x_s[d] = '0;
      sub_s[d] = 1'b0; cin_s[d] = 1'b0; out_ready_s[d] = 1'b0;
    end
    test_reset();
    for (int d = 0; d < 3; d++) begin
      test_directed(d);
      test_random(d, 15);
    end
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/add_sub_chunked.md
ADD_SUB_CHUNKED -- requirements
Module: add_sub_chunked

Interface
Parameters:
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits added per cycle; WIDTH SHALL be a nonzero multiple of CHUNK; N = WIDTH/CHUNK.
Ports:
REQ-003 SHALL have CLK  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have RESETN  input  1  reset, synchronous, active-low.
REQ-005 SHALL have in_valid  input  1  operands present.
REQ-006 SHALL have in_ready  output  1  block can accept operands.
REQ-007 SHALL have z  input  WIDTH  first operand.
REQ-008 SHALL have x  input  WIDTH  second operand.
REQ-009 SHALL have sub  input  1  0 = add, 1 = subtract (z - x).
REQ-010 SHALL have CIN  input  1  carry-in, add mode only.
REQ-011 SHALL have out_valid  output  1  result present.
REQ-012 SHALL have out_ready  input  1  consumer takes result.
REQ-013 SHALL have a  output  WIDTH  result.
REQ-014 SHALL have COUT  output  1  final carry out of MSB chunk.
REQ-015 SHALL have ovf  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 Accept = in_valid && in_ready at a rising edge: z, x, sub, CIN registered, chunk index k = 0, state -> RUN.
REQ-019 Inputs z, x, sub, CIN SHALL be ignored outside the accept edge.
REQ-020 Add: a = z + x + CIN mod 2^WIDTH; subtract: a = z + ~x + 1 mod 2^WIDTH, CIN ignored.
REQ-021 In RUN, each cycle SHALL compute chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) with carry-in = registered carry from chunk k-1 (chunk 0 uses CIN or 1 per mode), store result and carry, increment k.
REQ-022 After chunk N-1 state SHALL go to DONE: out_valid rises exactly N edges after the accept edge (N=1 legal: one RUN cycle).
REQ-023 COUT SHALL be the carry out of chunk N-1 (subtract: COUT=1 means no borrow).
REQ-024 ovf SHALL be 1 iff effective operands z and x' (x or ~x) have equal MSB and a's MSB differs.
REQ-025 In DONE, a/COUT/ovf SHALL hold stable until out_valid && out_ready; that edge returns to IDLE.
REQ-026 No new accept in RUN or DONE; back-to-back throughput is one op per N+2 cycles minimum.
REQ-027 a, COUT, ovf SHALL read 0 outside DONE.

Reset
REQ-028 RESETN low at a rising edge SHALL force IDLE, k=0, all data/carry registers 0, regardless of state (aborts RUN/DONE, result discarded).
REQ-029 Output values during/after reset: in_ready=1, out_valid=0, a=0, COUT=0, ovf=0.

Structure
REQ-030 Shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the elaboration check WIDTH % CHUNK == 0.
REQ-031 One sub-module, add_chunk_cin (CHUNK-bit adder: z, x, CIN in; a, COUT out, purely combinational), SHALL be instantiated once and time-shared across chunks.

Verification (WIDTH=32, CHUNK=8, N=4)
REQ-032 Add 0x000000FF + 0x00000001, CIN=0 -> a=0x00000100, COUT=0, ovf=0, out_valid exactly 4 edges after accept (carry crosses chunk boundary).
REQ-033 Sub 5 - 7 -> a=0xFFFFFFFE, COUT=0, ovf=0; sub 7 - 5 -> a=2, COUT=1.
REQ-034 Add 0x7FFFFFFF + 1 -> a=0x80000000, ovf=1, COUT=0; add 0xFFFFFFFF + 0 with CIN=1 -> a=0, COUT=1, ovf=0.
REQ-035 Hold out_ready=0 for 3 cycles in DONE -> a/COUT/ovf stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-036 RESETN low during 2nd RUN cycle -> next edge in_ready=1, out_valid=0, a=0; following op computes correctly.
REQ-037 Rerun 032-034 with CHUNK=32 (N=1) and CHUNK=1 (N=32): identical results, latency = N.
